// File: rtl/cmd_master.sv
// cmd_master
// ----------
// Host-side initiator for the byte-serial load/run/read-back command
// protocol used by the board's UART command interface.
//
// A single command is taken over a valid/ready handshake and broken into
// bytes for a UART transmitter. Read commands then collect a 2-byte reply
// from a UART receiver and return it as one word.
//
// Byte sequences on the transmit side:
//   ST (1)       : code
//   PM (2), DM(3): code, addr[7:0], addr MSB byte, data[7:0], data[15:8]
//   RE (4)       : code, addr[7:0], addr MSB byte, then 2 reply bytes
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      asynchronous active-high reset
//   cmd_valid  command request
//   cmd_ready  high only while idle; a command is accepted on valid&&ready
//   cmd_code   command code (ST=1, PM=2, DM=3, RE=4)
//   cmd_addr   target address
//   cmd_data   write data (PM/DM only)
//   tx_start   one-cycle pulse asking the transmitter to send d_out
//   d_out      byte to transmit, stable from tx_start until tx_done
//   tx_done    transmitter finished the current byte
//   rx_done    receiver byte-valid pulse
//   d_in       received byte
//   rsp_valid  one-cycle pulse, rsp_data holds a fresh read-back word
//   rsp_data   read-back word, held until the next read completes
//   busy       high whenever a command is in progress
//   err        one-cycle pulse on an illegal code or a reply timeout

module cmd_master #(
    parameter int SIZE        = 8,
    parameter int DATA_LENGTH = 16,
    parameter int ADDR_LENGTH = 11,
    parameter int TIMEOUT     = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_code,
    input  logic [ADDR_LENGTH-1:0] cmd_addr,
    input  logic [DATA_LENGTH-1:0] cmd_data,
    output logic                   tx_start,
    output logic [SIZE-1:0]        d_out,
    input  logic                   tx_done,
    input  logic                   rx_done,
    input  logic [SIZE-1:0]        d_in,
    output logic                   rsp_valid,
    output logic [DATA_LENGTH-1:0] rsp_data,
    output logic                   busy,
    output logic                   err
);

    localparam logic [7:0] CODE_ST = 8'd1;
    localparam logic [7:0] CODE_PM = 8'd2;
    localparam logic [7:0] CODE_DM = 8'd3;
    localparam logic [7:0] CODE_RE = 8'd4;

    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RX_LSB,
        RX_MSB
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [7:0]             code_q;
    logic [ADDR_LENGTH-1:0] addr_q;
    logic [DATA_LENGTH-1:0] data_q;
    logic [2:0]             index;
    logic [CNT_W-1:0]       counter;
    logic [SIZE-1:0]        shadow;

    logic                   legal_in;
    logic                   is_re;
    logic [2:0]             last_index;
    logic                   last_byte;
    logic                   timeout_hit;
    logic [2*SIZE-1:0]      addr_ext;
    logic [SIZE-1:0]        tx_byte;

    // Address is zero-extended so its upper part always fills a whole byte.
    assign addr_ext    = (2*SIZE)'(addr_q);
    assign legal_in    = (cmd_code == CODE_ST) || (cmd_code == CODE_PM) ||
                         (cmd_code == CODE_DM) || (cmd_code == CODE_RE);
    assign is_re       = (code_q == CODE_RE);
    assign last_byte   = (index == last_index);
    assign timeout_hit = (counter == CNT_W'(TIMEOUT - 1));

    // Index of the final byte depends only on the latched command.
    always_comb begin
        last_index = 3'd4;
        case (code_q)
            CODE_ST: last_index = 3'd0;
            CODE_RE: last_index = 3'd2;
            default: last_index = 3'd4;
        endcase
    end

    // Byte selected for transmission by the current index.
    always_comb begin
        tx_byte = '0;
        case (index)
            3'd0:    tx_byte = SIZE'(code_q);
            3'd1:    tx_byte = addr_ext[SIZE-1:0];
            3'd2:    tx_byte = addr_ext[2*SIZE-1:SIZE];
            3'd3:    tx_byte = data_q[SIZE-1:0];
            3'd4:    tx_byte = data_q[2*SIZE-1:SIZE];
            default: tx_byte = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Illegal codes are accepted but never leave IDLE.
    // In the reply states rx_done takes priority over a timeout in the
    // same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid && legal_in) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                next_state = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (!last_byte) begin
                        next_state = SEND;
                    end else if (is_re) begin
                        next_state = RX_LSB;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RX_LSB: begin
                if (rx_done) begin
                    next_state = RX_MSB;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            RX_MSB: begin
                if (rx_done || timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state. d_out is forced to zero outside the
    // transmit states so an idle block presents a clean bus.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        tx_start  = (state == SEND);
        d_out     = '0;
        if ((state == SEND) || (state == WAIT_TX)) begin
            d_out = tx_byte;
        end
    end

    // Datapath: command latches, byte index, reply timeout counter, reply
    // assembly and the registered rsp_valid / err pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            index     <= '0;
            counter   <= '0;
            shadow    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        code_q <= cmd_code;
                        addr_q <= cmd_addr;
                        data_q <= cmd_data;
                        index  <= '0;
                        if (!legal_in) begin
                            err <= 1'b1;
                        end
                    end
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (!last_byte) begin
                            index <= index + 3'd1;
                        end else if (is_re) begin
                            counter <= '0;
                        end
                    end
                end
                RX_LSB: begin
                    if (rx_done) begin
                        shadow  <= d_in;
                        counter <= '0;
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                RX_MSB: begin
                    if (rx_done) begin
                        rsp_data  <= {d_in, shadow};
                        rsp_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
